huffman_codegen: RTL and testbench
==================================

// Module: huffman_codegen
// PURPOSE
//  Downstream stage of the gray-level histogram/sort front end. Takes the six symbol
//  counts CNT1..CNT6 (presented with a CNT_valid pulse) and builds a 6-leaf Huffman tree.
//  Builds it by repeatedly merging the two lowest-ranked nodes.
//  Emits per-symbol codewords HC1..HC6 with bit masks M1..M6 and a one-cycle code_valid pulse.
// PARAMETERS
//  CW   8   count input width and codeword/mask output width
//  SW   11  internal node-sum width (holds 6*(2^CW-1))
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  reset       in   1   asynchronous, active-low reset
//  CNT_valid   in   1   one-cycle strobe: CNT1..CNT6 valid this cycle
//  CNT1..CNT6  in   CW  occurrence count of symbol 1..6
//  code_valid  out  1   one-cycle strobe: HC/M outputs hold a new result
//  HC1..HC6    out  CW  codeword of symbol n, right-aligned, root-side bit = MSB of code
//  M1..M6      out  CW  mask of symbol n: low len(n) bits set, rest 0
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, code_valid=0, HC1..HC6=0, M1..M6=0, merge counter=0,
//   all internal node/code/length registers 0.
//  States:
//   IDLE  -> LOAD  on CNT_valid=1. The CNT_valid cycle itself is the LOAD capture edge.
//   LOAD  -> MERGE (1 cycle). Captures 6 leaf nodes:
//         count=CNTn, tag=5+n (6..11), members={n}, code=0, len=0 for every symbol.
//   MERGE -> MERGE x5, k=1..5, then DONE.
//   DONE  -> IDLE (1 cycle). Registers HC/M, asserts code_valid.
//  Ranking: node A ranks below B if A.count<B.count, or counts equal and A.tag>B.tag.
//   Tags are unique, so ranking is total.
//  Merge step k (one cycle each):
//   - Select lowest-ranked active node L1 and second-lowest L2.
//   - Every symbol in L1: code[len]=1, len++. Every symbol in L2: code[len]=0, len++.
//   - L2's slot becomes the merged node: count=L1.count+L2.count (SW bits, no overflow), tag=5-k.
//   - L1's slot is deactivated; L1 symbols are re-pointed to L2's slot.
//   - Merged nodes therefore outrank equal-count leaves; later merges outrank earlier ones.
//  DONE: HCn=code(n); Mn=(1<<len(n))-1.
//   len is 1..5 and always fits CW=8; unused HC bits are 0.
//  Latency: CNT_valid in cycle t -> code_valid=1 in cycle t+7 exactly, for one cycle.
//  HC/M hold their values until the next DONE; they change only in the code_valid cycle.
//  CNT_valid while not IDLE is ignored (no queueing). CNT_valid in the DONE->IDLE cycle
//   is also ignored; accepted again from the first IDLE cycle.
//  Zero counts are legal: zero-count symbols still receive codes under the same tie rules.
//  All counts equal (including all 0) resolves purely by tag.
//  reset asserted mid-operation: immediate return to reset values. No code_valid for the
//   aborted job; next CNT_valid starts clean.
// TESTING
//  T1 CNT1..6=20,10,5,30,25,10 -> at t+7:
//     HC=03,03,05,00,02,04 and M=03,07,0F,03,03,0F (hex), code_valid high 1 cycle.
//  T2 CNT1..6 all 0 -> prefix-free set reproduced by the reference model for the tag rule.
//     Every Mn nonzero; sum of 2^-len(n) == 1 exactly.
//  T3 CNT1..6=255 all -> no sum overflow; lengths {2,2,3,3,3,3} in some assignment;
//     results match the model.
//  T4 second CNT_valid at t+2 and t+6 -> ignored; single code_valid at t+7.
//     A new CNT_valid at t+8 yields code_valid at t+15.
//  T5 reset low at t+4 -> outputs 0 at once, no code_valid; after release,
//     a fresh T1 job gives the T1 results.
//  T6 back-to-back jobs with different counts -> HC/M stable between pulses;
//     each job's values match the model.

Source files
------------

// File: rtl/huffman_codegen_if.sv
// huffman_codegen_if
//   Bundles the count-input side and the codeword-output side of the
//   Huffman code generator into a single interface.
//   Signals:
//     CNT_valid        one-cycle strobe, CNT1..CNT6 valid this cycle
//     CNT1..CNT6       CW-bit occurrence counts of symbols 1..6
//     code_valid       one-cycle strobe, HC/M hold a new result
//     HC1..HC6         CW-bit codewords, right-aligned, root-side bit is MSB
//     M1..M6           CW-bit masks with the low len(n) bits set
//   Modports:
//     master  drives the counts and receives the codes (upstream / bench)
//     slave   receives the counts and drives the codes (the generator)
interface huffman_codegen_if #(
    parameter int CW = 8
);
    logic          CNT_valid;
    logic [CW-1:0] CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
    logic          code_valid;
    logic [CW-1:0] HC1, HC2, HC3, HC4, HC5, HC6;
    logic [CW-1:0] M1, M2, M3, M4, M5, M6;

    modport master (
        output CNT_valid, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
        input  code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
        input  M1, M2, M3, M4, M5, M6
    );

    modport slave (
        input  CNT_valid, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
        output code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
        output M1, M2, M3, M4, M5, M6
    );
endinterface

// File: rtl/huffman_codegen.sv
// huffman_codegen
//   Builds a 6-leaf Huffman tree from six symbol counts by merging the two
//   lowest-ranked nodes five times, one merge per cycle, then presents the
//   per-symbol codewords and masks with a one-cycle code_valid pulse.
//   A job accepted in cycle t reports in cycle t+7.
//   Ports:
//     clk     system clock, rising edge
//     reset   asynchronous, active-low reset
//     bus     huffman_codegen_if slave modport (counts in, codes out)
module huffman_codegen #(
    parameter int CW = 8,
    parameter int SW = 11
) (
    input  logic                clk,
    input  logic                reset,
    huffman_codegen_if.slave    bus
);

    localparam int LW = $clog2(CW + 1);
    localparam int TW = 4;

    typedef enum logic [1:0] {IDLE, LOAD, MERGE, DONE} state_t;

    state_t        state, state_nxt;
    logic [2:0]    merge_cnt;
    logic          code_valid_q;

    // Node slots: slot i starts as leaf i; merged nodes reuse the L2 slot.
    logic [SW-1:0] node_cnt [6];
    logic [TW-1:0] node_tag [6];
    logic [5:0]    node_act;

    // Per-symbol state: which slot currently holds the symbol, code so far.
    logic [2:0]    sym_ptr  [6];
    logic [CW-1:0] sym_code [6];
    logic [LW-1:0] sym_len  [6];

    logic [CW-1:0] hc_q [6];
    logic [CW-1:0] m_q  [6];
    logic [CW-1:0] cnt_in [6];

    logic [2:0]    l1, l2;
    logic          found1, found2;

    logic [SW-1:0] cnt_nxt  [6];
    logic [TW-1:0] tag_nxt  [6];
    logic [5:0]    act_nxt;
    logic [2:0]    ptr_nxt  [6];
    logic [CW-1:0] code_nxt [6];
    logic [LW-1:0] len_nxt  [6];

    assign cnt_in[0] = bus.CNT1;
    assign cnt_in[1] = bus.CNT2;
    assign cnt_in[2] = bus.CNT3;
    assign cnt_in[3] = bus.CNT4;
    assign cnt_in[4] = bus.CNT5;
    assign cnt_in[5] = bus.CNT6;

    assign bus.code_valid = code_valid_q;
    assign bus.HC1 = hc_q[0];
    assign bus.HC2 = hc_q[1];
    assign bus.HC3 = hc_q[2];
    assign bus.HC4 = hc_q[3];
    assign bus.HC5 = hc_q[4];
    assign bus.HC6 = hc_q[5];
    assign bus.M1  = m_q[0];
    assign bus.M2  = m_q[1];
    assign bus.M3  = m_q[2];
    assign bus.M4  = m_q[3];
    assign bus.M5  = m_q[4];
    assign bus.M6  = m_q[5];

    // A ranks below B on a smaller count; on equal counts the larger tag is lower.
    function automatic logic ranks_below(input logic [SW-1:0] ca, input logic [TW-1:0] ta,
                                         input logic [SW-1:0] cb, input logic [TW-1:0] tb);
        return (ca < cb) || ((ca == cb) && (ta > tb));
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.CNT_valid) state_nxt = LOAD;
            LOAD:    state_nxt = MERGE;
            MERGE:   if (merge_cnt == 3'd4) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pick the lowest (L1) and second-lowest (L2) ranked active slots.
    always_comb begin
        l1     = '0;
        l2     = '0;
        found1 = 1'b0;
        found2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (node_act[i] && (!found1 ||
                ranks_below(node_cnt[i], node_tag[i], node_cnt[l1], node_tag[l1]))) begin
                l1     = 3'(i);
                found1 = 1'b1;
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (node_act[i] && (3'(i) != l1) && (!found2 ||
                ranks_below(node_cnt[i], node_tag[i], node_cnt[l2], node_tag[l2]))) begin
                l2     = 3'(i);
                found2 = 1'b1;
            end
        end
    end

    // One merge step. L2 symbols get a 0 at position len, which is already
    // 0 because bits above len are never set, so only their length advances.
    always_comb begin
        cnt_nxt  = node_cnt;
        tag_nxt  = node_tag;
        act_nxt  = node_act;
        ptr_nxt  = sym_ptr;
        code_nxt = sym_code;
        len_nxt  = sym_len;
        cnt_nxt[l2] = node_cnt[l1] + node_cnt[l2];
        tag_nxt[l2] = TW'(4) - TW'(merge_cnt);
        act_nxt[l1] = 1'b0;
        for (int s = 0; s < 6; s++) begin
            if (sym_ptr[s] == l1) begin
                code_nxt[s] = sym_code[s] | (CW'(1) << sym_len[s]);
                len_nxt[s]  = sym_len[s] + LW'(1);
                ptr_nxt[s]  = l2;
            end else if (sym_ptr[s] == l2) begin
                len_nxt[s]  = sym_len[s] + LW'(1);
            end
        end
    end

    // Leaves are captured on the CNT_valid edge; the final merge edge also
    // registers HC/M so they appear together with code_valid in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            merge_cnt    <= '0;
            code_valid_q <= 1'b0;
            node_act     <= '0;
            for (int i = 0; i < 6; i++) begin
                node_cnt[i] <= '0;
                node_tag[i] <= '0;
                sym_ptr[i]  <= '0;
                sym_code[i] <= '0;
                sym_len[i]  <= '0;
                hc_q[i]     <= '0;
                m_q[i]      <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.CNT_valid) begin
                        merge_cnt <= '0;
                        node_act  <= 6'b111111;
                        for (int i = 0; i < 6; i++) begin
                            node_cnt[i] <= SW'(cnt_in[i]);
                            node_tag[i] <= TW'(i + 6);
                            sym_ptr[i]  <= 3'(i);
                            sym_code[i] <= '0;
                            sym_len[i]  <= '0;
                        end
                    end
                end
                MERGE: begin
                    merge_cnt <= merge_cnt + 3'd1;
                    node_cnt  <= cnt_nxt;
                    node_tag  <= tag_nxt;
                    node_act  <= act_nxt;
                    sym_ptr   <= ptr_nxt;
                    sym_code  <= code_nxt;
                    sym_len   <= len_nxt;
                    if (merge_cnt == 3'd4) begin
                        code_valid_q <= 1'b1;
                        for (int s = 0; s < 6; s++) begin
                            hc_q[s] <= code_nxt[s];
                            m_q[s]  <= (CW'(1) << len_nxt[s]) - CW'(1);
                        end
                    end
                end
                DONE: code_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_codegen.sv
// tb_huffman_codegen
//   Scoreboard bench for huffman_codegen. Accepted jobs push the expected
//   codes (from a queue-based Huffman reference model, or the known T1
//   table) plus their due cycle; a negedge monitor pops and compares on
//   every code_valid and checks that HC/M hold steady between pulses.
module tb_huffman_codegen;

    typedef struct {
        logic [5:0][7:0] hc;
        logic [5:0][7:0] m;
        int              due;
    } exp_t;

    typedef struct {
        int       cnt;
        int       tag;
        bit [5:0] mem;
    } node_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   next_free = 0;
    exp_t sb[$];

    logic [5:0][7:0] dut_hc, dut_m, held_hc, held_m;
    logic [5:0][7:0] t1_cnt, t1_hc, t1_m, vals;

    huffman_codegen_if #(.CW(8)) bus ();

    huffman_codegen #(.CW(8), .SW(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign dut_hc = {bus.HC6, bus.HC5, bus.HC4, bus.HC3, bus.HC2, bus.HC1};
    assign dut_m  = {bus.M6, bus.M5, bus.M4, bus.M3, bus.M2, bus.M1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Plain Huffman: repeatedly pull the two lowest nodes out of a list.
    function automatic void model(input logic [5:0][7:0] c,
                                  output logic [5:0][7:0] hc, output logic [5:0][7:0] m);
        node_t nodes[$];
        node_t a, b, n;
        int    code[6];
        int    len[6];
        int    best;
        for (int i = 0; i < 6; i++) begin
            n.cnt = int'(c[i]);
            n.tag = 6 + i;
            n.mem = 6'(1 << i);
            nodes.push_back(n);
            code[i] = 0;
            len[i]  = 0;
        end
        for (int k = 1; k <= 5; k++) begin
            for (int pick = 0; pick < 2; pick++) begin
                best = 0;
                for (int j = 1; j < nodes.size(); j++)
                    if (nodes[j].cnt < nodes[best].cnt ||
                        (nodes[j].cnt == nodes[best].cnt && nodes[j].tag > nodes[best].tag))
                        best = j;
                if (pick == 0) a = nodes[best];
                else           b = nodes[best];
                nodes.delete(best);
            end
            for (int s = 0; s < 6; s++) begin
                if (a.mem[s]) begin
                    code[s] += (1 << len[s]);
                    len[s]++;
                end else if (b.mem[s]) begin
                    len[s]++;
                end
            end
            n.cnt = a.cnt + b.cnt;
            n.tag = 5 - k;
            n.mem = a.mem | b.mem;
            nodes.push_back(n);
        end
        for (int s = 0; s < 6; s++) begin
            hc[s] = 8'(code[s]);
            m[s]  = 8'((1 << len[s]) - 1);
        end
    endfunction

    // Called #1 after a rising edge; returns #1 after the next one.
    task automatic apply_stimulus(input logic [5:0][7:0] c, input bit use_t1);
        exp_t e;
        bit   accept;
        accept = (cyc >= next_free);
        bus.CNT1 = c[0]; bus.CNT2 = c[1]; bus.CNT3 = c[2];
        bus.CNT4 = c[3]; bus.CNT5 = c[4]; bus.CNT6 = c[5];
        bus.CNT_valid = 1'b1;
        if (accept) begin
            e.due = cyc + 7;
            if (use_t1) begin
                e.hc = t1_hc;
                e.m  = t1_m;
            end else begin
                model(c, e.hc, e.m);
            end
            sb.push_back(e);
            next_free = cyc + 8;
        end
        @(posedge clk);
        #1;
        bus.CNT_valid = 1'b0;
    endtask

    task automatic go_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic random_counts(output logic [5:0][7:0] c);
        int mode;
        mode = $urandom_range(0, 2);
        for (int i = 0; i < 6; i++)
            case (mode)
                0:       c[i] = 8'($urandom_range(0, 255));
                1:       c[i] = 8'($urandom_range(0, 3));
                default: c[i] = 8'($urandom_range(10, 40));
            endcase
    endtask

    // Monitor: pops on code_valid, otherwise checks HC/M are held.
    always @(negedge clk) begin
        exp_t e;
        int   kraft;
        if (!reset) begin
            held_hc = '0;
            held_m  = '0;
        end else if (bus.code_valid) begin
            if (sb.size() == 0) begin
                check_output("spurious_code_valid", bus.code_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check_output("latency", cyc, e.due);
                kraft = 0;
                for (int s = 0; s < 6; s++) begin
                    check_output($sformatf("HC%0d", s + 1), dut_hc[s], e.hc[s]);
                    check_output($sformatf("M%0d", s + 1), dut_m[s], e.m[s]);
                    kraft += 32 >> $countones(dut_m[s]);
                end
                check_output("kraft_sum", kraft, 32);
            end
            held_hc = dut_hc;
            held_m  = dut_m;
        end else begin
            check_output("hc_hold", dut_hc, held_hc);
            check_output("m_hold", dut_m, held_m);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int guard;
        t1_cnt = {8'd10, 8'd25, 8'd30, 8'd5, 8'd10, 8'd20};
        t1_hc  = {8'h04, 8'h02, 8'h00, 8'h05, 8'h03, 8'h03};
        t1_m   = {8'h0F, 8'h03, 8'h03, 8'h0F, 8'h07, 8'h03};
        bus.CNT_valid = 1'b0;
        bus.CNT1 = '0; bus.CNT2 = '0; bus.CNT3 = '0;
        bus.CNT4 = '0; bus.CNT5 = '0; bus.CNT6 = '0;
        reset = 1'b1;
        #3 reset = 1'b0;
        go_to(3);
        check_output("reset_code_valid", bus.code_valid, 1'b0);
        check_output("reset_hc", dut_hc, 48'h0);
        check_output("reset_m", dut_m, 48'h0);
        reset = 1'b1;
        next_free = cyc;

        // T1 with stray strobes at t+2, t+6, t+7 (T4), then a new job at t+8.
        t = cyc;
        apply_stimulus(t1_cnt, 1'b1);
        go_to(t + 2);
        vals = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        apply_stimulus(vals, 1'b0);
        go_to(t + 6);
        vals = {8'd90, 8'd0, 8'd7, 8'd7, 8'd200, 8'd1};
        apply_stimulus(vals, 1'b0);
        apply_stimulus(vals, 1'b0);
        go_to(t + 8);
        vals = {8'd3, 8'd60, 8'd9, 8'd14, 8'd2, 8'd33};
        apply_stimulus(vals, 1'b0);
        go_to(next_free);

        // T2 all zero, T3 all saturated.
        vals = '0;
        apply_stimulus(vals, 1'b0);
        go_to(next_free);
        vals = {6{8'd255}};
        apply_stimulus(vals, 1'b0);
        go_to(next_free + 2);

        // T5: reset mid-job, then a fresh T1 job.
        t = cyc;
        apply_stimulus(t1_cnt, 1'b1);
        go_to(t + 4);
        reset = 1'b0;
        sb.delete();
        #1;
        check_output("abort_code_valid", bus.code_valid, 1'b0);
        check_output("abort_hc", dut_hc, 48'h0);
        check_output("abort_m", dut_m, 48'h0);
        go_to(t + 7);
        reset = 1'b1;
        next_free = cyc;
        go_to(t + 12);
        apply_stimulus(t1_cnt, 1'b1);
        go_to(next_free);

        // T6: randomized back-to-back jobs with occasional ignored strobes.
        for (int j = 0; j < 40; j++) begin
            t = cyc;
            random_counts(vals);
            apply_stimulus(vals, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                go_to(t + int'($urandom_range(1, 7)));
                random_counts(vals);
                apply_stimulus(vals, 1'b0);
            end
            go_to(next_free + int'($urandom_range(0, 3)));
        end

        guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            @(posedge clk);
            guard++;
        end
        check_output("scoreboard_drained", sb.size(), 0);
        go_to(cyc + 10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
